// File: rtl/micro_out_prbs_checker_if.sv
// Sample/result bundle between a PRBS stream source and micro_out_prbs_checker.
// master drives samples and clear; slave is the checker and returns its status.
interface micro_out_prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             sample_valid;
  logic [7:0]       data_in;
  logic             clear;
  logic             locked;
  logic             err_flag;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic [7:0]       expected;

  modport master (
    output sample_valid, data_in, clear,
    input  locked, err_flag, err_count, sample_count, expected
  );

  modport slave (
    input  sample_valid, data_in, clear,
    output locked, err_flag, err_count, sample_count, expected
  );
endinterface

// File: rtl/micro_out_prbs_checker.sv
// PRBS8 (x^8+x^6+x^5+x^4+1) checker for a tile's uo_out bus: self-synchronises,
// then flywheels the LFSR and counts mismatches and samples while locked.
//
// state  | meaning
// ACQ    | waiting for a non-zero sample to use as seed
// VERIFY | seeded; counting consecutive matches towards lock
// LOCKED | synchronised; LFSR free-runs, errors counted
module micro_out_prbs_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  micro_out_prbs_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [3:0]       LOSS_LAST = 4'(LOSS_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       st_q, st_d;
  logic [3:0]       match_run_q, match_run_d;
  logic [3:0]       miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;

  logic [7:0]       expected;
  logic             match;

  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always_comb begin
    expected = lfsr_nxt(st_q);
    match    = (bus.data_in == expected);
  end

  always_comb begin
    state_d        = state_q;
    st_d           = st_q;
    match_run_d    = match_run_q;
    miss_run_d     = miss_run_q;
    locked_d       = locked_q;
    err_flag_d     = 1'b0;
    err_count_d    = err_count_q;
    sample_count_d = sample_count_q;

    if (bus.sample_valid) begin
      case (state_q)
        ACQ: begin
          // all-zero is the LFSR lock-up state, never a usable seed
          if (bus.data_in != 8'h00) begin
            st_d        = bus.data_in;
            match_run_d = 4'd0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            st_d        = bus.data_in;
            match_run_d = match_run_q + 4'd1;
            if (match_run_q == LOCK_LAST) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_run_d = 4'd0;
            end
          end else if (bus.data_in != 8'h00) begin
            st_d        = bus.data_in;
            match_run_d = 4'd0;
          end else begin
            state_d = ACQ;
          end
        end
        LOCKED: begin
          // flywheel: the incoming data never reseeds once locked
          st_d = expected;
          if (sample_count_q != CNT_MAX) begin
            sample_count_d = sample_count_q + CNT_W'(1);
          end
          if (match) begin
            miss_run_d = 4'd0;
          end else begin
            err_flag_d = 1'b1;
            miss_run_d = miss_run_q + 4'd1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_run_q == LOSS_LAST) begin
              state_d    = ACQ;
              locked_d   = 1'b0;
              miss_run_d = 4'd0;
            end
          end
        end
        default: begin
          state_d  = ACQ;
          locked_d = 1'b0;
        end
      endcase
    end

    // clear overrides any same-cycle increment but leaves err_flag alone
    if (bus.clear) begin
      err_count_d    = '0;
      sample_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ACQ;
      st_q           <= 8'h00;
      match_run_q    <= 4'd0;
      miss_run_q     <= 4'd0;
      locked_q       <= 1'b0;
      err_flag_q     <= 1'b0;
      err_count_q    <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      st_q           <= st_d;
      match_run_q    <= match_run_d;
      miss_run_q     <= miss_run_d;
      locked_q       <= locked_d;
      err_flag_q     <= err_flag_d;
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.err_flag     = err_flag_q;
  assign bus.err_count    = err_count_q;
  assign bus.sample_count = sample_count_q;
  assign bus.expected     = expected;

endmodule

// File: tb/tb_micro_out_prbs_checker.sv
// Directed bench for micro_out_prbs_checker: default instance for lock/error/clear
// scenarios, and a CNT_W=4, LOSS_COUNT=15 instance for counter saturation.
module tb_micro_out_prbs_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  micro_out_prbs_checker_if #(.CNT_W(16)) bus_a ();
  micro_out_prbs_checker_if #(.CNT_W(4))  bus_b ();

  micro_out_prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  micro_out_prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic [7:0] d, input logic c);
    @(negedge clk);
    bus_a.sample_valid = 1'b1;
    bus_a.data_in      = d;
    bus_a.clear        = c;
    @(posedge clk);
    #1;
    bus_a.sample_valid = 1'b0;
    bus_a.clear        = 1'b0;
  endtask

  task automatic step_b(input logic [7:0] d);
    @(negedge clk);
    bus_b.sample_valid = 1'b1;
    bus_b.data_in      = d;
    @(posedge clk);
    #1;
    bus_b.sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] st_m;
  int         err_m;
  int         smp_m;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.sample_valid = 1'b0; bus_a.data_in = 8'h00; bus_a.clear = 1'b0;
    bus_b.sample_valid = 1'b0; bus_b.data_in = 8'h00; bus_b.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_locked",   bus_a.locked,       0);
    chk("reset_err_flag", bus_a.err_flag,     0);
    chk("reset_err_cnt",  bus_a.err_count,    0);
    chk("reset_smp_cnt",  bus_a.sample_count, 0);
    chk("reset_expected", bus_a.expected,     8'h00);

    // lock acquisition
    step_a(8'h01, 0);
    chk("seed_expected", bus_a.expected, 8'h02);
    step_a(8'h02, 0); step_a(8'h04, 0); step_a(8'h08, 0);
    chk("lock_not_yet", bus_a.locked, 0);
    step_a(8'h11, 0);
    chk("lock_locked",   bus_a.locked,       1);
    chk("lock_expected", bus_a.expected,     8'h23);
    chk("lock_err_cnt",  bus_a.err_count,    0);
    chk("lock_smp_cnt",  bus_a.sample_count, 0);
    bus_a.data_in = 8'hFF;
    idle_cycle();
    chk("idle_hold_exp", bus_a.expected, 8'h23);

    // single error then recovery
    step_a(8'hFF, 0);
    chk("err_flag_hi",  bus_a.err_flag,     1);
    chk("err_err_cnt",  bus_a.err_count,    1);
    chk("err_smp_cnt",  bus_a.sample_count, 1);
    chk("err_expected", bus_a.expected,     8'h47);
    idle_cycle();
    chk("err_flag_lo",  bus_a.err_flag,     0);
    step_a(8'h47, 0);
    chk("match_flag",   bus_a.err_flag,     0);
    chk("match_err",    bus_a.err_count,    1);
    chk("match_smp",    bus_a.sample_count, 2);
    chk("match_locked", bus_a.locked,       1);
    chk("match_exp",    bus_a.expected,     8'h8E);

    // loss of lock
    do_reset();
    step_a(8'h01, 0); step_a(8'h02, 0); step_a(8'h04, 0); step_a(8'h08, 0); step_a(8'h11, 0);
    step_a(8'h00, 0); step_a(8'h00, 0); step_a(8'h00, 0);
    chk("loss_3_locked", bus_a.locked, 1);
    step_a(8'h00, 0);
    chk("loss_locked",   bus_a.locked,       0);
    chk("loss_err_cnt",  bus_a.err_count,    4);
    chk("loss_smp_cnt",  bus_a.sample_count, 4);
    chk("loss_expected", bus_a.expected,     8'h38);
    step_a(8'h00, 0); step_a(8'h00, 0);
    chk("acq_zero_exp",  bus_a.expected,     8'h38);
    chk("acq_zero_err",  bus_a.err_count,    4);
    chk("acq_zero_flag", bus_a.err_flag,     0);

    // false seed then reseed onto chain from 05
    step_a(8'h01, 0);
    chk("fs_seed_exp", bus_a.expected, 8'h02);
    step_a(8'h05, 0);
    chk("fs_reseed_exp", bus_a.expected, 8'h0A);
    step_a(8'h0A, 0); step_a(8'h15, 0); step_a(8'h2B, 0);
    chk("fs_not_yet", bus_a.locked, 0);
    step_a(8'h56, 0);
    chk("fs_locked",  bus_a.locked,       1);
    chk("fs_exp",     bus_a.expected,     8'hAD);
    chk("fs_err_ret", bus_a.err_count,    4);
    chk("fs_smp_ret", bus_a.sample_count, 4);

    // clear beats same-cycle increment
    step_a(8'h00, 1);
    chk("clr_err_cnt", bus_a.err_count,    0);
    chk("clr_smp_cnt", bus_a.sample_count, 0);
    chk("clr_flag",    bus_a.err_flag,     1);
    chk("clr_locked",  bus_a.locked,       1);
    chk("clr_exp",     bus_a.expected,     8'h5B);

    // reset while in VERIFY, then confirm match progress was discarded
    step_a(8'h00, 0); step_a(8'h00, 0); step_a(8'h00, 0);
    chk("clr_loss", bus_a.locked, 0);
    step_a(8'h01, 0); step_a(8'h02, 0);
    do_reset();
    chk("rstv_locked", bus_a.locked,       0);
    chk("rstv_flag",   bus_a.err_flag,     0);
    chk("rstv_err",    bus_a.err_count,    0);
    chk("rstv_smp",    bus_a.sample_count, 0);
    chk("rstv_exp",    bus_a.expected,     8'h00);
    step_a(8'h02, 0); step_a(8'h04, 0); step_a(8'h08, 0); step_a(8'h11, 0);
    chk("rstv_relock_short", bus_a.locked, 0);
    step_a(8'h23, 0);
    chk("rstv_relock", bus_a.locked, 1);

    // saturation on the narrow-counter instance
    step_b(8'h01); step_b(8'h02); step_b(8'h04); step_b(8'h08); step_b(8'h11);
    chk("sat_locked", bus_b.locked, 1);
    st_m  = 8'h11;
    err_m = 0;
    smp_m = 0;
    for (int i = 1; i <= 22; i++) begin
      if (i == 10 || i == 20) begin
        step_b(lfsr_nxt(st_m));
      end else begin
        step_b(8'h00);
        if (err_m < 15) err_m++;
      end
      if (smp_m < 15) smp_m++;
      st_m = lfsr_nxt(st_m);
      chk("sat_err_cnt", bus_b.err_count,    err_m);
      chk("sat_smp_cnt", bus_b.sample_count, smp_m);
      chk("sat_expected", bus_b.expected,    lfsr_nxt(st_m));
    end
    chk("sat_err_final", bus_b.err_count,    15);
    chk("sat_smp_final", bus_b.sample_count, 15);
    chk("sat_locked_end", bus_b.locked,      1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
